// File: rtl/intc_pkg.sv
// rtl/intc_pkg.sv - shared constants for the interrupt controller register window
package intc_pkg;

  localparam int NUM_IRQ = 8;
  localparam int IDX_W   = 3;

  // Word offsets, i.e. iAddress[3:2]
  localparam logic [1:0] OFF_STATUS = 2'd0;
  localparam logic [1:0] OFF_MASK   = 2'd1;
  localparam logic [1:0] OFF_EDGE   = 2'd2;
  localparam logic [1:0] OFF_ID     = 2'd3;

  localparam int ID_VALID_BIT = 31;

endpackage

// File: rtl/intc_prio_enc.sv
// rtl/intc_prio_enc.sv - lowest-index-wins priority encoder producing the ID index and valid flag
module intc_prio_enc
  import intc_pkg::*;
(
  input  logic [NUM_IRQ-1:0] req_i,
  output logic [IDX_W-1:0]   idx_o,
  output logic               valid_o
);

  // Scan from the top down so the lowest set index is the last one written
  always_comb begin
    idx_o = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (req_i[i]) idx_o = IDX_W'(i);
    end
  end

  assign valid_o = |req_i;

endmodule

// File: rtl/interrupt_controller.sv
// rtl/interrupt_controller.sv - 8-source interrupt controller (STATUS/MASK/EDGE/ID); INTC_INPUT_SYNC_EN adds a 2-flop input synchronizer
module interrupt_controller
  import intc_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'hFFFF0400,
  parameter int          NUM_IRQ   = 8
) (
  input  logic               iCLK,
  input  logic               iRST,
  input  logic [NUM_IRQ-1:0] iIRQ,
  input  logic [31:0]        iAddress,
  input  logic               iReadEnable,
  input  logic               iWriteEnable,
  input  logic [3:0]         iByteEnable,
  input  logic [31:0]        iWriteData,
  output logic [31:0]        oReadData,
  output logic               oHit,
  output logic [NUM_IRQ-1:0] oPendingInterrupt
);

  logic [NUM_IRQ-1:0] irq_s;
  logic [NUM_IRQ-1:0] prev_q;
  logic [NUM_IRQ-1:0] status_q, status_d;
  logic [NUM_IRQ-1:0] mask_q, mask_d;
  logic [NUM_IRQ-1:0] edge_q, edge_d;
  logic [NUM_IRQ-1:0] pend_q;
  logic [NUM_IRQ-1:0] edge_evt;
  logic [NUM_IRQ-1:0] w1c;
  logic [NUM_IRQ-1:0] wr_byte;
  logic [1:0]         arm_cnt_q;
  logic               armed;
  logic [1:0]         off;
  logic               wr_en;
  logic [IDX_W-1:0]   id_idx;
  logic               id_valid;
  logic [31:0]        id_word;

`ifdef INTC_INPUT_SYNC_EN
  // Samples are not trustworthy until the sync pipe and prev_q have all refilled
  localparam int ARM_LAT = 3;
  logic [NUM_IRQ-1:0] sync1_q, sync2_q;

  always_ff @(posedge iCLK) begin
    if (!iRST) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= iIRQ;
      sync2_q <= sync1_q;
    end
  end

  assign irq_s = sync2_q;
`else
  localparam int ARM_LAT = 1;
  assign irq_s = iIRQ;
`endif

  assign oHit    = (iAddress[31:4] == BASE_ADDR[31:4]);
  assign off     = iAddress[3:2];
  assign wr_en   = oHit & iWriteEnable & iByteEnable[0];
  assign wr_byte = iWriteData[NUM_IRQ-1:0];

  // An input already high when reset releases must not look like a fresh edge
  assign armed    = (arm_cnt_q >= 2'(ARM_LAT));
  assign edge_evt = irq_s & ~prev_q & {NUM_IRQ{armed}};
  assign w1c      = (wr_en && off == OFF_STATUS) ? wr_byte : '0;

  // Edge sources latch until W1C (a same-cycle set wins); level sources mirror the input
  always_comb begin
    status_d = (edge_q & ((status_q & ~w1c) | edge_evt)) | (~edge_q & irq_s);
    mask_d   = (wr_en && off == OFF_MASK) ? wr_byte : mask_q;
    edge_d   = (wr_en && off == OFF_EDGE) ? wr_byte : edge_q;
  end

  always_ff @(posedge iCLK) begin
    if (!iRST) begin
      status_q  <= '0;
      mask_q    <= '0;
      edge_q    <= '0;
      prev_q    <= '0;
      pend_q    <= '0;
      arm_cnt_q <= '0;
    end else begin
      status_q <= status_d;
      mask_q   <= mask_d;
      edge_q   <= edge_d;
      prev_q   <= irq_s;
      pend_q   <= status_q & mask_q;
      if (!armed) arm_cnt_q <= arm_cnt_q + 2'd1;
    end
  end

  assign oPendingInterrupt = pend_q;

  intc_prio_enc u_prio_enc (
    .req_i   (status_q & mask_q),
    .idx_o   (id_idx),
    .valid_o (id_valid)
  );

  always_comb begin
    id_word               = '0;
    id_word[ID_VALID_BIT] = id_valid;
    id_word[IDX_W-1:0]    = id_idx;
  end

  always_comb begin
    oReadData = 32'h0;
    if (oHit && iReadEnable) begin
      case (off)
        OFF_STATUS: oReadData = 32'(status_q);
        OFF_MASK:   oReadData = 32'(mask_q);
        OFF_EDGE:   oReadData = 32'(edge_q);
        default:    oReadData = id_word;
      endcase
    end
  end

  logic unused_bits;
  assign unused_bits = ^{iAddress[1:0], iByteEnable[3:1], iWriteData[31:NUM_IRQ]};

endmodule

// File: tb/tb_interrupt_controller.sv
// tb/tb_interrupt_controller.sv - directed self-checking bench for interrupt_controller
module tb_interrupt_controller;

  localparam logic [31:0] BASE = 32'hFFFF0400;
`ifdef INTC_INPUT_SYNC_EN
  localparam int PEND_LAT = 2;
`else
  localparam int PEND_LAT = 0;
`endif
  localparam int OUT_LAT = PEND_LAT + 1;

  logic        iCLK = 1'b0;
  logic        iRST;
  logic [7:0]  iIRQ;
  logic [31:0] iAddress;
  logic        iReadEnable;
  logic        iWriteEnable;
  logic [3:0]  iByteEnable;
  logic [31:0] iWriteData;
  logic [31:0] oReadData;
  logic        oHit;
  logic [7:0]  oPendingInterrupt;

  int checks = 0;
  int errors = 0;

  interrupt_controller #(.BASE_ADDR(BASE), .NUM_IRQ(8)) dut (
    .iCLK              (iCLK),
    .iRST              (iRST),
    .iIRQ              (iIRQ),
    .iAddress          (iAddress),
    .iReadEnable       (iReadEnable),
    .iWriteEnable      (iWriteEnable),
    .iByteEnable       (iByteEnable),
    .iWriteData        (iWriteData),
    .oReadData         (oReadData),
    .oHit              (oHit),
    .oPendingInterrupt (oPendingInterrupt)
  );

  always #5 iCLK = ~iCLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge iCLK);
  endtask

  // Called at a negedge; the write lands on the following posedge
  task automatic bus_write(input logic [3:0] off, input logic [31:0] data, input logic [3:0] be);
    iAddress     = BASE + {28'h0, off};
    iWriteData   = data;
    iByteEnable  = be;
    iWriteEnable = 1'b1;
    @(negedge iCLK);
    iWriteEnable = 1'b0;
    iByteEnable  = 4'h0;
  endtask

  task automatic rd_chk(input string tag, input logic [3:0] off, input logic [31:0] exp);
    iAddress    = BASE + {28'h0, off};
    iReadEnable = 1'b1;
    #1;
    check_eq(tag, oReadData, exp);
    iReadEnable = 1'b0;
  endtask

  initial begin
    iRST = 1'b0; iIRQ = '0; iAddress = '0; iReadEnable = 1'b0;
    iWriteEnable = 1'b0; iByteEnable = '0; iWriteData = '0;
    wait_neg(3);
    iRST = 1'b1;

    rd_chk("rst_status", 4'h0, 32'h0);
    rd_chk("rst_mask",   4'h4, 32'h0);
    rd_chk("rst_edge",   4'h8, 32'h0);
    rd_chk("rst_id",     4'hC, 32'h0);
    check_eq("rst_pend", 32'(oPendingInterrupt), 32'h0);

    // Edge source on bit 2, one-cycle pulse, latency to oPendingInterrupt
    bus_write(4'h8, 32'h04, 4'b0001);
    bus_write(4'h4, 32'h04, 4'b0001);
    iIRQ = 8'h04;
    @(negedge iCLK);
    iIRQ = 8'h00;
    for (int k = 0; k < 5; k++) begin
      check_eq($sformatf("edge_lat%0d", k), 32'(oPendingInterrupt), (k >= OUT_LAT) ? 32'h04 : 32'h0);
      @(negedge iCLK);
    end
    rd_chk("edge_status", 4'h0, 32'h04);
    rd_chk("edge_id",     4'hC, 32'h80000002);
    bus_write(4'h0, 32'h04, 4'b0001);
    rd_chk("edge_w1c", 4'h0, 32'h0);
    wait_neg(1);
    check_eq("edge_pend_clr", 32'(oPendingInterrupt), 32'h0);

    // Level source on bit 5: W1C does not stick while the input is high
    bus_write(4'h8, 32'h00, 4'b0001);
    bus_write(4'h4, 32'hFF, 4'b0001);
    iIRQ = 8'h20;
    wait_neg(4);
    rd_chk("lvl_set", 4'h0, 32'h20);
    bus_write(4'h0, 32'h20, 4'b0001);
    rd_chk("lvl_w1c", 4'h0, 32'h20);
    wait_neg(2);
    rd_chk("lvl_hold", 4'h0, 32'h20);
    check_eq("lvl_pend", 32'(oPendingInterrupt), 32'h20);
    iIRQ = 8'h00;
    wait_neg(4);
    rd_chk("lvl_drop", 4'h0, 32'h0);

    // Priority of the ID register against the mask
    bus_write(4'h8, 32'hFF, 4'b0001);
    iIRQ = 8'h42;
    @(negedge iCLK);
    iIRQ = 8'h00;
    wait_neg(4);
    bus_write(4'h4, 32'h40, 4'b0001);
    rd_chk("id_mask40", 4'hC, 32'h80000006);
    bus_write(4'h4, 32'h42, 4'b0001);
    rd_chk("id_mask42", 4'hC, 32'h80000001);
    rd_chk("id_status", 4'h0, 32'h42);
    wait_neg(1);
    check_eq("id_pend", 32'(oPendingInterrupt), 32'h42);
    bus_write(4'h0, 32'hFF, 4'b0001);
    rd_chk("id_clr_status", 4'h0, 32'h0);
    rd_chk("id_clr_id",     4'hC, 32'h0);

    // Set and W1C on bit 3 in the same cycle
    iIRQ = 8'h08;
    @(negedge iCLK);
    iIRQ = 8'h00;
    wait_neg(4);
    rd_chk("race_pre", 4'h0, 32'h08);
    iIRQ = 8'h08;
    wait_neg(PEND_LAT);
    bus_write(4'h0, 32'h08, 4'b0001);
    iIRQ = 8'h00;
    rd_chk("race_set_wins", 4'h0, 32'h08);
    bus_write(4'h0, 32'h08, 4'b0001);
    rd_chk("race_clr", 4'h0, 32'h0);

    // Byte lane 0 gates writes
    bus_write(4'h4, 32'h00, 4'b0010);
    rd_chk("be_mask", 4'h4, 32'h42);

    // Window decode
    iAddress    = BASE + 32'h10;
    iReadEnable = 1'b1;
    #1;
    check_eq("win_out_hit",  32'(oHit), 32'h0);
    check_eq("win_out_data", oReadData, 32'h0);
    iAddress = BASE + 32'h4;
    #1;
    check_eq("win_in_hit", 32'(oHit), 32'h1);
    iReadEnable = 1'b0;

    // Reset mid-operation with an input held high
    iIRQ = 8'h10;
    @(negedge iCLK);
    iIRQ = 8'h01;
    wait_neg(4);
    rd_chk("pre_rst_status", 4'h0, 32'h11);
    iRST = 1'b0;
    @(negedge iCLK);
    rd_chk("in_rst_status", 4'h0, 32'h0);
    check_eq("in_rst_pend", 32'(oPendingInterrupt), 32'h0);
    iRST = 1'b1;
    wait_neg(6);
    bus_write(4'h8, 32'hFF, 4'b0001);
    bus_write(4'h0, 32'hFF, 4'b0001);
    wait_neg(6);
    rd_chk("post_rst_status", 4'h0, 32'h0);
    rd_chk("post_rst_mask",   4'h4, 32'h0);
    check_eq("post_rst_pend", 32'(oPendingInterrupt), 32'h0);
    iIRQ = 8'h00;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/interrupt_controller.md
INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'hFFFF0400, 16-byte-aligned base of the register window.
REQ-002 SHALL have parameter NUM_IRQ, default 8, number of interrupt sources (fixed 8 in this revision).
REQ-003 SHALL have port iCLK, input, 1, the single clock; all logic is synchronous to its rising edge.
REQ-004 SHALL have port iRST, input, 1, reset that is synchronous and active-low.
REQ-005 SHALL have port iIRQ, input, 8, raw peripheral interrupt requests, possibly asynchronous.
REQ-006 SHALL have port iAddress, input, 32, CPU data-bus address.
REQ-007 SHALL have ports iReadEnable and iWriteEnable, each input, 1, CPU data-bus strobes.
REQ-008 SHALL have port iByteEnable, input, 4, data-bus byte lanes.
REQ-009 SHALL have port iWriteData, input, 32, CPU write data.
REQ-010 SHALL have port oReadData, output, 32, register read data.
REQ-011 SHALL have port oHit, output, 1, high when iAddress falls inside the window, for the system read mux.
REQ-012 SHALL have port oPendingInterrupt, output, 8, masked pending vector driving the CPU's 8-bit pending-interrupt input.

Function
REQ-013 Window hit: iAddress[31:4] == BASE_ADDR[31:4]; offset = iAddress[3:2].
REQ-014 Registers SHALL be STATUS (0x0, pending bits, read; write-1-to-clear), MASK (0x4, rw), EDGE (0x8, rw, 1=rising-edge, 0=level), and ID (0xC, read-only).
REQ-015 Writes SHALL occur on the clock edge when hit & iWriteEnable & iByteEnable[0]; only bits [7:0] are used; writes to ID are ignored.
REQ-016 Reads SHALL be combinational: oReadData = zero-extended register when hit & iReadEnable, else 32'h0.
REQ-017 Edge source: the pending bit SHALL set on a 0->1 transition of the sampled input and hold until cleared by W1C.
REQ-018 Level source: the pending bit SHALL equal the sampled input level; W1C has no lasting effect while the level is high.
REQ-019 A set event and a W1C to the same bit in the same cycle: the set SHALL win.
REQ-020 oPendingInterrupt SHALL be registered and equal STATUS & MASK, one cycle after STATUS/MASK update.
REQ-021 ID SHALL read {valid, 28'b0, idx[2:0]}: valid = |(STATUS&MASK); idx = lowest-numbered masked pending bit (bit 0 highest priority); 0 when none pending.
REQ-022 Changing an EDGE bit SHALL NOT alter current pending state; the edge detector's previous-sample register keeps tracking regardless of mode.

Reset
REQ-023 With iRST low at a clock edge, STATUS, MASK, EDGE, synchronizer and previous-sample flops, and oPendingInterrupt SHALL clear to 0.
REQ-024 Reset mid-operation SHALL discard pending events; an input already high after reset SHALL NOT produce an edge event.

Configuration
REQ-025 Macro INTC_INPUT_SYNC_EN defined: iIRQ SHALL pass through a 2-flop synchronizer; an input first sampled high at edge t sets pending at edge t+2, and oPendingInterrupt rises at edge t+3.
REQ-026 Macro INTC_INPUT_SYNC_EN undefined: iIRQ SHALL be used directly; pending sets at edge t, and oPendingInterrupt rises at edge t+1.

Structure
REQ-027 Package intc_pkg SHALL hold register offset constants, NUM_IRQ, and the ID valid-bit position.
REQ-028 Sub-module intc_prio_enc (8-to-3 lowest-index priority encoder with valid output) SHALL compute ID.

Verification
REQ-029 Reset, then read 0x0/0x4/0x8/0xC -> all 32'h0; oPendingInterrupt = 8'h00.
REQ-030 EDGE=8'h04, MASK=8'h04, pulse iIRQ[2] for 1 cycle -> STATUS = 8'h04; oPendingInterrupt = 8'h04 at the REQ-025/026 latency; ID = 32'h80000002; write 0x0 = 8'h04 -> STATUS = 0.
REQ-031 EDGE=0, MASK=8'hFF, hold iIRQ[5] high, write 0x0 = 8'h20 -> STATUS bit 5 stays 1; drop iIRQ[5] -> bit 5 clears.
REQ-032 iIRQ[1] and iIRQ[6] pending, MASK=8'h40 -> ID = 32'h80000006; then MASK=8'h42 -> ID = 32'h80000001.
REQ-033 Edge on bit 3 in the same cycle as a W1C of bit 3 -> STATUS bit 3 = 1; write with iByteEnable=4'b0010 -> no register change; access at BASE_ADDR+0x10 -> oHit=0, oReadData=0.
